// File: rtl/uart_mmio_bridge_pkg.sv
// Package for the UART MMIO bridge.
// Pulls in the shared register/status definitions and provides the address
// decode helpers used by the data-memory bus mux to generate ce and reg_sel.
package uart_mmio_bridge_pkg;

    `include "uart_defs.vh"

    typedef logic [7:0] byte_t;

    // True when a memory-stage address targets one of the two UART registers.
    function automatic logic addr_hits_uart(input logic [31:0] addr);
        return (addr == UART_DATA_ADDR) || (addr == UART_STATUS_ADDR);
    endfunction

    // Register select for an address already known to hit the UART.
    function automatic logic addr_to_reg_sel(input logic [31:0] addr);
        return (addr == UART_STATUS_ADDR) ? REG_STATUS : REG_DATA;
    endfunction

endpackage

// File: rtl/uart_defs.vh
// Shared constants for the UART MMIO bridge: register selects, STATUS bit
// positions and the MMIO addresses the data-memory address decoder matches.
`ifndef UART_DEFS_VH
`define UART_DEFS_VH

localparam logic REG_DATA   = 1'b0;
localparam logic REG_STATUS = 1'b1;

localparam int ST_TX_RDY = 0;
localparam int ST_RX_AVL = 1;
localparam int ST_RX_OVF = 2;
localparam int ST_TX_OVF = 3;

localparam logic [31:0] UART_DATA_ADDR   = 32'hBFD0_03F8;
localparam logic [31:0] UART_STATUS_ADDR = 32'hBFD0_03FC;

`endif

// File: rtl/uart_mmio_bridge_byte_fifo.sv
// byte_fifo: synchronous byte FIFO with occupancy counter.
// Ports:
//   clk, rst (sync, active-low)
//   push, din  : enqueue din when there is room (or a pop frees room)
//   pop        : dequeue head; ignored while empty
//   dout       : current head, combinational from storage
//   empty, full
// Storage is not reset; only pointers and count are.
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign dout  = mem[rd_ptr];

    // A pop on empty is dropped; a pop on full frees the slot the push needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge: CPU word-access front end for the serial port driver.
// Ports:
//   clk, rst (sync, active-low)
//   ce, we, reg_sel, wdata : one bus access per ce cycle (DATA/STATUS)
//   rdata, ack             : registered response, one cycle after ce
//   irq                    : RX FIFO non-empty
//   tx_data, tx_req, tx_ack: TX FIFO head handshake to the driver
//   rx_data, rx_valid      : received byte strobe from the driver
module uart_mmio_bridge
    import uart_mmio_bridge_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic        reg_sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        irq,
    output logic [7:0]  tx_data,
    output logic        tx_req,
    input  logic        tx_ack,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
);

    logic        data_wr;
    logic        data_rd;
    logic        stat_rd;
    logic        tx_empty;
    logic        tx_full;
    logic        rx_empty;
    logic        rx_full;
    byte_t       rx_head;
    logic        tx_ovf;
    logic        rx_ovf;
    logic        tx_ovf_set;
    logic        rx_ovf_set;
    logic [31:0] status_word;
    logic        unused_wdata_hi;

    assign unused_wdata_hi = ^wdata[31:8];

    assign data_wr = ce &  we & (reg_sel == REG_DATA);
    assign data_rd = ce & ~we & (reg_sel == REG_DATA);
    assign stat_rd = ce & ~we & (reg_sel == REG_STATUS);

    byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_wr),
        .din   (wdata[7:0]),
        .pop   (tx_ack),
        .dout  (tx_data),
        .empty (tx_empty),
        .full  (tx_full)
    );

    byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .din   (rx_data),
        .pop   (data_rd),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full)
    );

    assign tx_req = ~tx_empty;
    assign irq    = ~rx_empty;

    // A pop in the same cycle frees a slot on a full FIFO, so no overflow then.
    assign tx_ovf_set = data_wr  & tx_full & ~tx_ack;
    assign rx_ovf_set = rx_valid & rx_full & ~data_rd;

    always_comb begin
        status_word            = '0;
        status_word[ST_TX_RDY] = ~tx_full;
        status_word[ST_RX_AVL] = ~rx_empty;
        status_word[ST_RX_OVF] = rx_ovf;
        status_word[ST_TX_OVF] = tx_ovf;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ack    <= 1'b0;
            rdata  <= '0;
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            ack <= ce;
            // A new overflow in the clearing cycle keeps the flag set.
            tx_ovf <= tx_ovf_set | (tx_ovf & ~stat_rd);
            rx_ovf <= rx_ovf_set | (rx_ovf & ~stat_rd);
            if (data_rd)
                rdata <= rx_empty ? 32'h0 : {24'h0, rx_head};
            else if (stat_rd)
                rdata <= status_word;
        end
    end

endmodule

// File: doc/uart_mmio_bridge.md
# uart_mmio_bridge

CPU-side front end for the board serial port: it turns word accesses from the MIPS memory stage into byte traffic for the UART chip driver. It buffers outgoing bytes in a TX FIFO that feeds the driver's transmit request, and incoming bytes in an RX FIFO that the CPU drains by polling or by interrupt. It sits between the data-memory bus mux and the serial port driver that owns the wrn/rdn/tbre/tsre/data_ready pins.

## Interface
- DEPTH, 8: entries per FIFO; power of two, 2..64.
- AW, log2(DEPTH): FIFO pointer width, derived.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- ce  in  1  bus access strobe; each cycle high is one access.
- we  in  1  1 = write, 0 = read; sampled with ce.
- reg_sel  in  1  0 = DATA register (0xBFD003F8), 1 = STATUS register (0xBFD003FC).
- wdata  in  32  write data; only bits [7:0] are used.
- rdata  out  32  registered read data.
- ack  out  1  pulses the cycle after each ce cycle.
- irq  out  1  high while the RX FIFO is non-empty.
- tx_data  out  8  head of the TX FIFO.
- tx_req  out  1  high while the TX FIFO is non-empty.
- tx_ack  in  1  one-cycle pulse from the driver: byte taken.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle pulse: rx_data is valid.

## Operation
- DATA write: push wdata[7:0] to the TX FIFO. If the FIFO is full, drop the byte and set tx_ovf.
- DATA read: if the RX FIFO is non-empty, rdata = {24'b0, head} and pop. If it is empty, rdata = 0 and nothing pops.
- STATUS read returns:
  - bit0 = TX not full
  - bit1 = RX non-empty
  - bit2 = rx_ovf
  - bit3 = tx_ovf
  - all other bits 0
- A STATUS read clears both ovf flags at the same edge it samples them. An overflow arriving in that same cycle wins: the flag stays 1.
- STATUS write is ignored; it still acks.
- TX side:
  - tx_req = !tx_empty; tx_data = head, valid whenever tx_req = 1.
  - tx_ack pops one entry. tx_ack while the FIFO is empty is ignored.
- RX side:
  - rx_valid pushes rx_data.
  - If the FIFO is full, the byte is dropped and rx_ovf is set.
- Simultaneous push and pop on one FIFO:
  - full: the pop frees a slot, so the push succeeds; no overflow is raised, count is unchanged.
  - empty: the pop is ignored and the push succeeds; count becomes 1.
- Pointers wrap modulo DEPTH. The count is AW+1 bits, so full = (count == DEPTH).
- Reset clears FIFO pointers, counts, both ovf flags, rdata = 0 and ack = 0. As a result tx_req = 0 and irq = 0. FIFO storage is not cleared.
- Reset asserted mid-transfer discards all buffered bytes. A tx_ack arriving in that cycle is ignored.

## Timing
- All state is updated on the rising edge of clk.
- ack and rdata are valid one cycle after ce: 1-cycle latency. Back-to-back ce cycles give back-to-back acks.
- A DATA read's pop and a STATUS read's flag clear happen at the same edge that registers rdata.
- Pushes and pops take effect at the edge. tx_req, tx_data, irq and the status bits reflect the new state in the following cycle.
- A byte written to an empty TX FIFO at edge N gives tx_req = 1 after edge N.
- A byte received at edge N is readable by a DATA read issued after edge N, i.e. with ce = 1 in cycle N+1 or later.
- No combinational path from ce/we/reg_sel to any output.

## Structure
- Shared include file uart_defs.vh holds:
  - register select values
  - status bit indices (TX_RDY = 0, RX_AVL = 1, RX_OVF = 2, TX_OVF = 3)
  - MMIO base addresses, used by the address decoder
- One sub-module, byte_fifo (parameters DEPTH, AW), instantiated twice.
  - Ports: clk, rst, push, din, pop, dout, empty, full.
  - Implements the push/pop-at-full/empty rules above.
  - dout is the head, combinational from storage.
- The top level holds the bus decode, the ovf flags, the rdata/ack registers and irq.

## Test plan
- Reset then idle: rst = 0 for 2 cycles -> ack = 0, rdata = 0, tx_req = 0, irq = 0; a STATUS read returns 0x00000001.
- TX path: write DATA 0x41, then 0x42 -> tx_req = 1 with tx_data = 0x41; tx_ack -> tx_data = 0x42; second tx_ack -> tx_req = 0.
- TX overflow: 9 DATA writes with no tx_ack (DEPTH = 8) -> STATUS = 0x00000008; the ninth byte is absent from the drained sequence; a second STATUS read returns bit3 = 0.
- RX path: rx_valid with 0x5A -> irq = 1, STATUS = 0x00000003; DATA read -> rdata = 0x0000005A, then irq = 0; an extra DATA read returns 0.
- RX full boundary:
  - fill 8 bytes; a 9th rx_valid in the same cycle as a DATA read -> no rx_ovf, count stays 8, the 9th byte is last out.
  - a 10th rx_valid without a read -> rx_ovf = 1.
- Reset mid-operation: 3 bytes queued in each FIFO, then rst = 0 for 1 cycle -> tx_req = 0, irq = 0, STATUS = 0x00000001.
